// File: rtl/ray_direction_queue.sv
// Packs every three pushed words into an {z,y,x} record and queues it; record visible 1 cycle after the completing push.
// Producer cannot stall: a completed record arriving while full and not popping is dropped and flagged sticky.
module ray_direction_queue #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iFifoPush,
    input  logic [WORD_W-1:0]   iFifoData,
    input  logic                iClear,
    output logic                oRayValid,
    output logic [3*WORD_W-1:0] oRayData,
    input  logic                iRayReady,
    output logic [PTR_W:0]      oRayCount,
    output logic                oPartial,
    output logic                oOverflow
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [1:0]          compIdx;
    logic [WORD_W-1:0]   xReg;
    logic [WORD_W-1:0]   yReg;
    logic [3*WORD_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;
    logic [PTR_W:0]      countNext;
    logic                overflow;

    logic complete;
    logic pop;
    logic isFull;
    logic write;
    logic drop;

    assign complete = iFifoPush && (compIdx == 2'd2);
    assign pop      = oRayValid && iRayReady;
    assign isFull   = (count == FULL_COUNT);
    // A same-cycle pop frees the slot, so a full queue can still take the record.
    assign write    = complete && (!isFull || pop);
    assign drop     = complete && isFull && !pop;

    always_comb begin
        countNext = count;
        if (write && !pop) begin
            countNext = count + COUNT_ONE;
        end else if (!write && pop) begin
            countNext = count - COUNT_ONE;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            compIdx  <= 2'd0;
            xReg     <= '0;
            yReg     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (iClear) begin
            compIdx  <= 2'd0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (iFifoPush) begin
                case (compIdx)
                    2'd0: begin
                        xReg    <= iFifoData;
                        compIdx <= 2'd1;
                    end
                    2'd1: begin
                        yReg    <= iFifoData;
                        compIdx <= 2'd2;
                    end
                    default: compIdx <= 2'd0;
                endcase
            end
            if (write) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            count <= countNext;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Record storage carries no reset; contents are meaningless while count is zero.
    always_ff @(posedge iClock) begin
        if (!iClear && write) begin
            storage[tail] <= {iFifoData, yReg, xReg};
        end
    end

    assign oRayValid = (count != '0);
    assign oRayData  = storage[head];
    assign oRayCount = count;
    assign oPartial  = (compIdx != 2'd0);
    assign oOverflow = overflow;

endmodule

// File: tb/tb_ray_direction_queue.sv
// Directed bench for ray_direction_queue: assembly, fill/overflow, full-with-pop, streaming, clear and async reset.
module tb_ray_direction_queue;

    logic        iClock;
    logic        iReset;
    logic        iFifoPush;
    logic [31:0] iFifoData;
    logic        iClear;
    logic        oRayValid;
    logic [95:0] oRayData;
    logic        iRayReady;
    logic [4:0]  oRayCount;
    logic        oPartial;
    logic        oOverflow;

    int compared;
    int mismatched;

    ray_direction_queue #(.WORD_W(32), .DEPTH(16), .PTR_W(4)) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iFifoPush (iFifoPush),
        .iFifoData (iFifoData),
        .iClear    (iClear),
        .oRayValid (oRayValid),
        .oRayData  (oRayData),
        .iRayReady (iRayReady),
        .oRayCount (oRayCount),
        .oPartial  (oPartial),
        .oOverflow (oOverflow)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    function automatic logic [95:0] rec(input int b);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        x = b;
        y = b + 1;
        z = b + 2;
        return {z, y, x};
    endfunction

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic pushWord(input int w);
        iFifoPush = 1'b1;
        iFifoData = w;
        tick();
        iFifoPush = 1'b0;
    endtask

    task automatic pushRec(input int b);
        pushWord(b);
        pushWord(b + 1);
        pushWord(b + 2);
    endtask

    task automatic popOne();
        iRayReady = 1'b1;
        tick();
        iRayReady = 1'b0;
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        iFifoPush = 1'b0;
        iFifoData = '0;
        iClear = 1'b0;
        iRayReady = 1'b0;
        tick();
        tick();
        iReset = 1'b0;
        tick();
        compared++;
        if ({oRayValid, oRayCount, oPartial, oOverflow} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_state: valid/count/partial/ovf got %b expected 00000000",
                     {oRayValid, oRayCount, oPartial, oOverflow});
        end
    endtask

    task automatic test_basic();
        pushRec(1);
        compared++;
        if (oRayValid !== 1'b1 || oRayData !== 96'h00000003_00000002_00000001) begin
            mismatched++;
            $display("FAIL basic_record: valid=%b data=%h expected valid=1 data=%h",
                     oRayValid, oRayData, 96'h00000003_00000002_00000001);
        end
        compared++;
        if (oRayCount !== 5'd1 || oPartial !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_count: count=%0d partial=%b expected 1/0", oRayCount, oPartial);
        end
        popOne();
        compared++;
        if (oRayValid !== 1'b0 || oRayCount !== 5'd0) begin
            mismatched++;
            $display("FAIL basic_drain: valid=%b count=%0d expected 0/0", oRayValid, oRayCount);
        end
    endtask

    task automatic test_partial();
        pushWord(32'hA);
        pushWord(32'hB);
        compared++;
        if (oPartial !== 1'b1 || oRayValid !== 1'b0) begin
            mismatched++;
            $display("FAIL partial_state: partial=%b valid=%b expected 1/0", oPartial, oRayValid);
        end
        pushWord(32'hC);
        compared++;
        if (oRayValid !== 1'b1 || oPartial !== 1'b0 || oRayData !== rec(32'hA)) begin
            mismatched++;
            $display("FAIL partial_complete: valid=%b partial=%b data=%h expected 1/0/%h",
                     oRayValid, oPartial, oRayData, rec(32'hA));
        end
        popOne();
    endtask

    task automatic test_fill_overflow();
        for (int k = 0; k < 17; k++) pushRec(3 * k);
        compared++;
        if (oRayCount !== 5'd16 || oOverflow !== 1'b1) begin
            mismatched++;
            $display("FAIL fill_count_ovf: count=%0d ovf=%b expected 16/1", oRayCount, oOverflow);
        end
        for (int k = 0; k < 16; k++) begin
            compared++;
            if (oRayValid !== 1'b1 || oRayData !== rec(3 * k)) begin
                mismatched++;
                $display("FAIL fill_drain_%0d: valid=%b data=%h expected 1/%h",
                         k, oRayValid, oRayData, rec(3 * k));
            end
            popOne();
        end
        compared++;
        if (oRayValid !== 1'b0 || oRayCount !== 5'd0 || oOverflow !== 1'b1) begin
            mismatched++;
            $display("FAIL fill_empty_sticky: valid=%b count=%0d ovf=%b expected 0/0/1",
                     oRayValid, oRayCount, oOverflow);
        end
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        compared++;
        if (oOverflow !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_ovf: ovf=%b expected 0", oOverflow);
        end
    endtask

    task automatic test_full_pop();
        logic [95:0] exp;
        for (int k = 0; k < 16; k++) pushRec(100 + 3 * k);
        pushWord(500);
        pushWord(501);
        iFifoPush = 1'b1;
        iFifoData = 502;
        iRayReady = 1'b1;
        tick();
        iFifoPush = 1'b0;
        iRayReady = 1'b0;
        compared++;
        if (oRayCount !== 5'd16 || oOverflow !== 1'b0) begin
            mismatched++;
            $display("FAIL fullpop_count: count=%0d ovf=%b expected 16/0", oRayCount, oOverflow);
        end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? rec(100 + 3 * (i + 1)) : rec(500);
            compared++;
            if (oRayValid !== 1'b1 || oRayData !== exp) begin
                mismatched++;
                $display("FAIL fullpop_drain_%0d: valid=%b data=%h expected 1/%h",
                         i, oRayValid, oRayData, exp);
            end
            popOne();
        end
        compared++;
        if (oRayValid !== 1'b0) begin
            mismatched++;
            $display("FAIL fullpop_empty: valid=%b expected 0", oRayValid);
        end
    endtask

    task automatic test_back_to_back();
        int rx;
        int maxCount;
        rx = 0;
        maxCount = 0;
        iRayReady = 1'b1;
        for (int j = 0; j < 120; j++) begin
            iFifoPush = 1'b1;
            iFifoData = 1000 + j;
            tick();
            if (int'(oRayCount) > maxCount) maxCount = int'(oRayCount);
            if (oRayValid === 1'b1) begin
                compared++;
                if (oRayData !== rec(1000 + 3 * rx)) begin
                    mismatched++;
                    $display("FAIL stream_rec_%0d: data=%h expected %h",
                             rx, oRayData, rec(1000 + 3 * rx));
                end
                rx++;
            end
        end
        iFifoPush = 1'b0;
        tick();
        iRayReady = 1'b0;
        compared++;
        if (rx !== 40 || maxCount > 1 || oOverflow !== 1'b0 || oRayCount !== 5'd0) begin
            mismatched++;
            $display("FAIL stream_summary: received=%0d maxcount=%0d ovf=%b count=%0d expected 40/<=1/0/0",
                     rx, maxCount, oOverflow, oRayCount);
        end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 5; k++) pushRec(200 + 3 * k);
        pushWord(300);
        iClear = 1'b1;
        iFifoPush = 1'b1;
        iFifoData = 301;
        iRayReady = 1'b1;
        tick();
        iClear = 1'b0;
        iFifoPush = 1'b0;
        iRayReady = 1'b0;
        compared++;
        if ({oRayValid, oRayCount, oPartial, oOverflow} !== 8'b0) begin
            mismatched++;
            $display("FAIL clear_state: valid/count/partial/ovf got %b expected 00000000",
                     {oRayValid, oRayCount, oPartial, oOverflow});
        end
        pushRec(7);
        compared++;
        if (oRayCount !== 5'd1 || oRayData !== rec(7)) begin
            mismatched++;
            $display("FAIL clear_restart: count=%0d data=%h expected 1/%h", oRayCount, oRayData, rec(7));
        end
        popOne();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 17; k++) pushRec(400 + 3 * k);
        pushWord(900);
        compared++;
        if (oOverflow !== 1'b1 || oPartial !== 1'b1 || oRayCount !== 5'd16) begin
            mismatched++;
            $display("FAIL areset_setup: ovf=%b partial=%b count=%0d expected 1/1/16",
                     oOverflow, oPartial, oRayCount);
        end
        #2;
        iReset = 1'b1;
        #1;
        compared++;
        if ({oRayValid, oRayCount, oPartial, oOverflow} !== 8'b0) begin
            mismatched++;
            $display("FAIL areset_immediate: valid/count/partial/ovf got %b expected 00000000",
                     {oRayValid, oRayCount, oPartial, oOverflow});
        end
        #1;
        iReset = 1'b0;
        tick();
        pushRec(4);
        compared++;
        if (oRayCount !== 5'd1 || oRayData !== rec(4)) begin
            mismatched++;
            $display("FAIL areset_restart: count=%0d data=%h expected 1/%h", oRayCount, oRayData, rec(4));
        end
        popOne();
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_partial();
        test_fill_overflow();
        test_full_pop();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
